fpu_div: RTL
============

# fpu_div

Iterative single-precision (IEEE-754 binary32) floating-point divider, Rs1 / Rs2, for the floating-point ALU. It is the inverse-direction companion of the combinational FP multiplier.
- Multi-cycle: restoring radix-2 mantissa division, one quotient bit per clock, with a Start/Done handshake so the FPU controller can stall the pipeline.
- Same number conventions as the multiplier: truncation, no rounding, flush-to-zero, overflow flag.

## Interface
- FLEN, 32, operand/result width
- MANTISSA, 23, stored fraction bits
- EXP, 8, exponent bits
- CLK  input  1  clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- En  input  1  clock enable; when 0, all state and registers hold
- Start  input  1  request; sampled only in IDLE with En=1
- Rs1  input  FLEN  dividend, captured on accepted Start
- Rs2  input  FLEN  divisor, captured on accepted Start
- Busy  output  1  high from the cycle after acceptance until Done
- Done  output  1  one-cycle pulse; Result and flags valid
- Result  output  FLEN  quotient; held until next Done
- overflow  output  1  exponent overflow, held with Result
- underflow  output  1  exponent underflow, held with Result
- div_zero  output  1  divisor zero, dividend nonzero; held with Result

## Operation
- FSM states: IDLE, DIV, NORM.
  - IDLE -> DIV on Start=1.
  - DIV -> NORM after 25 iterations, counted by a 5-bit counter 0..24.
  - NORM -> IDLE unconditionally.
- Capture on accepted Start:
  - sign = Rs1[31]^Rs2[31]
  - 10-bit signed exponent e = exp1 - exp2 + 127
  - A = {1, mnt1}, B = {1, mnt2}, both 24 bits
  - remainder R (25 bits) = A; quotient q (25 bits) = 0
  - special-case flags: z1 = (exp1==0), z2 = (exp2==0)
- Flush-to-zero: any operand with exponent 0 is zero, fraction ignored.
- exp==255 inputs get no special handling; they are processed arithmetically.
- Each DIV cycle:
  - if R >= B, shift q left with a 1 and set R = (R - B) << 1
  - else shift q left with a 0 and set R = R << 1
- After 25 iterations, q[24] is the integer bit.
- NORM:
  - if q[24]=1: mantissa = q[23:1], exponent = e
  - else: mantissa = q[22:0], exponent = e - 1
  - truncate; no rounding, no sticky bit
- NORM result priority (first match wins):
  - z1 & z2 -> 32'h7FC00000 (canonical NaN), all flags 0
  - z2 -> {sign, 8'hFF, 23'b0}, div_zero=1
  - z1 -> {sign, 31'b0}
  - exponent >= 255 -> {sign, 8'hFF, 23'b0}, overflow=1
  - exponent <= 0 -> {sign, 31'b0}, underflow=1
  - else -> {sign, exponent[7:0], mantissa}
- Special cases still take the full latency; latency is data-independent.
- Start while Busy is ignored; no queueing.
- Start held high continuously gives back-to-back operations: re-accepted in the IDLE cycle after Done.

## Timing
- Reset values: state IDLE; Busy=0; Done=0; Result=0; overflow=0; underflow=0; div_zero=0; counter=0.
- rst_n low mid-operation aborts immediately to the reset values; no Done is produced.
- Start sampled high at edge T0 (IDLE, En=1): Busy=1 after T0.
- DIV iterations occur at edges T1..T25.
- NORM registers Result and flags at T26:
  - Done=1 and Busy=0 after T26.
  - Done clears after T27.
- Latency from accepting edge to Done: 26 cycles. Throughput: one operation per 27 cycles.
- Each cycle with En=0 extends latency by one cycle.
- A Done pulse that is already asserted holds while En=0.
- Result and flags change only at the NORM edge.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) -> Result 0x40400000, Done exactly 26 cycles after Start, flags 0.
- 0x3F800000 / 0x40400000 (1.0/3.0) -> 0x3EAAAAAA (truncated); 0xC0000000 / 0x3F000000 (-2/0.5) -> 0xC0800000.
- Zero cases:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, div_zero=1
  - 0x00000000 / 0x00000000 -> 0x7FC00000
  - 0x80000000 / 0x40000000 -> 0x80000000
- Exponent range:
  - 0x7F000000 / 0x00800000 -> 0x7F800000, overflow=1
  - 0x00800000 / 0x7F000000 -> 0x00000000, underflow=1
- Start pulsed at cycle 5 of an operation -> ignored, first Result unchanged; En=0 for 3 cycles mid-DIV -> Done at 29 cycles, correct value.
- rst_n asserted at iteration 10 -> all outputs 0 asynchronously, no Done; a new Start after release completes normally in 26 cycles.

Source files
------------

// File: rtl/fpu_div_if.sv
// Handshake and operand/result bundle between the FPU controller and the iterative divider.
interface fpu_div_if #(
    parameter int FLEN = 32
);
    logic            En;
    logic            Start;
    logic [FLEN-1:0] Rs1;
    logic [FLEN-1:0] Rs2;
    logic            Busy;
    logic            Done;
    logic [FLEN-1:0] Result;
    logic            overflow;
    logic            underflow;
    logic            div_zero;

    modport master (
        output En, Start, Rs1, Rs2,
        input  Busy, Done, Result, overflow, underflow, div_zero
    );

    modport slave (
        input  En, Start, Rs1, Rs2,
        output Busy, Done, Result, overflow, underflow, div_zero
    );
endinterface

// File: rtl/fpu_div.sv
// Iterative binary32 divider: restoring radix-2 mantissa division, one quotient bit per clock.
// Truncating, flush-to-zero, exponent 255 treated as an ordinary number.
module fpu_div #(
    parameter int FLEN     = 32,
    parameter int MANTISSA = 23,
    parameter int EXP      = 8
) (
    input logic      CLK,
    input logic      rst_n,
    fpu_div_if.slave bus
);
    localparam int                    QW   = MANTISSA + 2;
    localparam logic [4:0]            LAST = 5'(QW - 1);
    localparam logic signed [EXP+1:0] BIAS = (EXP+2)'((1 << (EXP - 1)) - 1);
    localparam logic signed [EXP+1:0] EMAX = (EXP+2)'((1 << EXP) - 1);
    localparam logic signed [EXP+1:0] EONE = (EXP+2)'(1);
    localparam logic signed [EXP+1:0] EZRO = (EXP+2)'(0);

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    state_t                state;
    logic                  sign;
    logic                  z1;
    logic                  z2;
    logic signed [EXP+1:0] exp_q;
    logic [MANTISSA:0]     divisor;
    logic [QW-1:0]         rem;
    logic [QW-1:0]         quo;
    logic [4:0]            count;

    logic                  rem_ge;
    logic [MANTISSA:0]     rem_diff;
    logic signed [EXP+1:0] exp_n;
    logic [MANTISSA-1:0]   mnt_n;

    // While R >= B the difference is below B, so its low MANTISSA+1 bits are exact.
    always_comb begin
        rem_ge   = rem >= {1'b0, divisor};
        rem_diff = rem[MANTISSA:0] - divisor;
        if (quo[QW-1]) begin
            mnt_n = quo[MANTISSA:1];
            exp_n = exp_q;
        end else begin
            mnt_n = quo[MANTISSA-1:0];
            exp_n = exp_q - EONE;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            sign          <= 1'b0;
            z1            <= 1'b0;
            z2            <= 1'b0;
            exp_q         <= '0;
            divisor       <= '0;
            rem           <= '0;
            quo           <= '0;
            bus.Busy      <= 1'b0;
            bus.Done      <= 1'b0;
            bus.Result    <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
            bus.div_zero  <= 1'b0;
        end else if (bus.En) begin
            case (state)
                IDLE: begin
                    bus.Done <= 1'b0;
                    if (bus.Start) begin
                        state    <= DIV;
                        bus.Busy <= 1'b1;
                        sign     <= bus.Rs1[FLEN-1] ^ bus.Rs2[FLEN-1];
                        exp_q    <= $signed((EXP+2)'(bus.Rs1[FLEN-2 -: EXP]))
                                  - $signed((EXP+2)'(bus.Rs2[FLEN-2 -: EXP])) + BIAS;
                        z1       <= bus.Rs1[FLEN-2 -: EXP] == '0;
                        z2       <= bus.Rs2[FLEN-2 -: EXP] == '0;
                        divisor  <= {1'b1, bus.Rs2[MANTISSA-1:0]};
                        rem      <= {2'b01, bus.Rs1[MANTISSA-1:0]};
                        quo      <= '0;
                        count    <= '0;
                    end
                end
                DIV: begin
                    quo <= {quo[QW-2:0], rem_ge};
                    rem <= rem_ge ? {rem_diff, 1'b0} : {rem[MANTISSA:0], 1'b0};
                    if (count == LAST) begin
                        state <= NORM;
                        count <= '0;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                NORM: begin
                    state         <= IDLE;
                    bus.Busy      <= 1'b0;
                    bus.Done      <= 1'b1;
                    bus.overflow  <= 1'b0;
                    bus.underflow <= 1'b0;
                    bus.div_zero  <= 1'b0;
                    // Zero operands are resolved before any exponent range check.
                    if (z1 && z2) begin
                        bus.Result <= {1'b0, {EXP{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};
                    end else if (z2) begin
                        bus.Result   <= {sign, {EXP{1'b1}}, {MANTISSA{1'b0}}};
                        bus.div_zero <= 1'b1;
                    end else if (z1) begin
                        bus.Result <= {sign, {(FLEN-1){1'b0}}};
                    end else if (exp_n >= EMAX) begin
                        bus.Result   <= {sign, {EXP{1'b1}}, {MANTISSA{1'b0}}};
                        bus.overflow <= 1'b1;
                    end else if (exp_n <= EZRO) begin
                        bus.Result    <= {sign, {(FLEN-1){1'b0}}};
                        bus.underflow <= 1'b1;
                    end else begin
                        bus.Result <= {sign, exp_n[EXP-1:0], mnt_n};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
